// File: rtl/frame_column_loader_if.sv
// Configuration word stream into the column loader: 32-bit data with valid/ready.
interface frame_column_loader_if;
    logic [31:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;

    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/frame_column_loader.sv
// Column configuration front-end: takes a header word plus one data word per row,
// then pulses the one-hot frame strobe selected by the header.
module frame_column_loader #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumRows         = 16,
    parameter int StrobeWidth     = 1
) (
    input  logic                                CLK,
    input  logic                                resetn,
    frame_column_loader_if.slave                cfg,
    output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
    output logic [MaxFramesPerCol-1:0]          FrameStrobe,
    output logic                                frame_done,
    output logic                                hdr_err,
    input  logic                                err_clr,
    output logic                                busy
);

    localparam int ROW_W = $clog2(NumRows);

    typedef enum logic [1:0] {IDLE, LOAD, STROBE, GAP} state_t;

    state_t                     state_reg, state_next;
    logic [4:0]                 frame_idx_reg, frame_idx_next;
    logic [ROW_W-1:0]           row_cnt_reg, row_cnt_next;
    logic [3:0]                 strobe_cnt_reg, strobe_cnt_next;
    logic                       hdr_err_reg, hdr_err_next;
    logic                       frame_done_reg, frame_done_next;
    logic [MaxFramesPerCol-1:0] frame_strobe_reg, frame_strobe_next;
    logic                       hdr_set;
    logic                       xfer;
    logic                       hdr_ok;

    assign cfg.cfg_ready = (state_reg == IDLE) || (state_reg == LOAD);
    assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
    assign hdr_ok        = (cfg.cfg_data[31:20] == 12'hFAB) &&
                           ({27'd0, cfg.cfg_data[4:0]} < 32'(MaxFramesPerCol));
    assign busy          = (state_reg != IDLE);

    assign FrameStrobe = frame_strobe_reg;
    assign frame_done  = frame_done_reg;
    assign hdr_err     = hdr_err_reg;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_reg        <= IDLE;
            frame_idx_reg    <= '0;
            row_cnt_reg      <= '0;
            strobe_cnt_reg   <= '0;
            hdr_err_reg      <= 1'b0;
            frame_done_reg   <= 1'b0;
            frame_strobe_reg <= '0;
        end else begin
            state_reg        <= state_next;
            frame_idx_reg    <= frame_idx_next;
            row_cnt_reg      <= row_cnt_next;
            strobe_cnt_reg   <= strobe_cnt_next;
            hdr_err_reg      <= hdr_err_next;
            frame_done_reg   <= frame_done_next;
            frame_strobe_reg <= frame_strobe_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        frame_idx_next  = frame_idx_reg;
        row_cnt_next    = row_cnt_reg;
        strobe_cnt_next = strobe_cnt_reg;
        hdr_set         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (xfer) begin
                    if (hdr_ok) begin
                        frame_idx_next = cfg.cfg_data[4:0];
                        row_cnt_next   = '0;
                        state_next     = LOAD;
                    end else begin
                        hdr_set = 1'b1;
                    end
                end
            end
            LOAD: begin
                // Every word here is row data, even if it looks like a header.
                if (xfer) begin
                    if (row_cnt_reg == ROW_W'(NumRows - 1)) begin
                        row_cnt_next    = '0;
                        strobe_cnt_next = '0;
                        state_next      = STROBE;
                    end else begin
                        row_cnt_next = row_cnt_reg + 1'b1;
                    end
                end
            end
            STROBE: begin
                if (strobe_cnt_reg == 4'(StrobeWidth - 1)) begin
                    state_next = GAP;
                end else begin
                    strobe_cnt_next = strobe_cnt_reg + 4'd1;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A new error in the same cycle beats the clear request.
        hdr_err_next    = hdr_set ? 1'b1 : (err_clr ? 1'b0 : hdr_err_reg);
        frame_done_next = (state_next == GAP);
    end

    // Strobe and done are registered from the next state so they line up with state_reg.
    for (genvar gi = 0; gi < MaxFramesPerCol; gi++) begin : g_strobe
        assign frame_strobe_next[gi] = (state_next == STROBE) && (frame_idx_reg == 5'(gi));
    end

    for (genvar gi = 0; gi < NumRows; gi++) begin : g_row
        logic [FrameBitsPerRow-1:0] row_reg;

        always_ff @(posedge CLK or negedge resetn) begin
            if (!resetn) begin
                row_reg <= '0;
            end else if ((state_reg == LOAD) && xfer && (row_cnt_reg == ROW_W'(gi))) begin
                row_reg <= cfg.cfg_data;
            end
        end

        assign FrameData[gi*FrameBitsPerRow +: FrameBitsPerRow] = row_reg;
    end

endmodule

// File: tb/tb_frame_column_loader.sv
// Bench for frame_column_loader: header table, streamed frames, strobe scoreboard,
// stalls, asynchronous resets and per-cycle strobe invariants on two strobe widths.
module tb_frame_column_loader;

    localparam int NR = 16;
    localparam int NF = 20;

    logic        CLK = 1'b0;
    logic        resetn = 1'b0;
    logic        sel = 1'b0;
    logic        err_clr = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [31:0] cfg_data = 32'd0;

    always #5 CLK = ~CLK;

    frame_column_loader_if bus_a ();
    frame_column_loader_if bus_b ();

    assign bus_a.cfg_data  = cfg_data;
    assign bus_a.cfg_valid = cfg_valid & ~sel;
    assign bus_b.cfg_data  = cfg_data;
    assign bus_b.cfg_valid = cfg_valid & sel;

    logic [NR*32-1:0] data_a, data_b, obs_data;
    logic [NF-1:0]    strobe_a, strobe_b, obs_strobe;
    logic             done_a, done_b, err_a, err_b, busy_a, busy_b;
    logic             obs_done, obs_err, obs_busy, obs_ready;

    frame_column_loader #(.FrameBitsPerRow(32), .MaxFramesPerCol(NF), .NumRows(NR), .StrobeWidth(1)) dut_a (
        .CLK(CLK), .resetn(resetn), .cfg(bus_a.slave), .FrameData(data_a), .FrameStrobe(strobe_a),
        .frame_done(done_a), .hdr_err(err_a), .err_clr(err_clr & ~sel), .busy(busy_a)
    );

    frame_column_loader #(.FrameBitsPerRow(32), .MaxFramesPerCol(NF), .NumRows(NR), .StrobeWidth(3)) dut_b (
        .CLK(CLK), .resetn(resetn), .cfg(bus_b.slave), .FrameData(data_b), .FrameStrobe(strobe_b),
        .frame_done(done_b), .hdr_err(err_b), .err_clr(err_clr & sel), .busy(busy_b)
    );

    assign obs_data   = sel ? data_b   : data_a;
    assign obs_strobe = sel ? strobe_b : strobe_a;
    assign obs_done   = sel ? done_b   : done_a;
    assign obs_err    = sel ? err_b    : err_a;
    assign obs_busy   = sel ? busy_b   : busy_a;
    assign obs_ready  = sel ? bus_b.cfg_ready : bus_a.cfg_ready;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [NF-1:0] strobe;
        int            width;
    } sb_t;
    sb_t sb_q[$];
    sb_t sb_e;

    typedef struct {
        logic [31:0] word;
        logic        accept;
        logic [31:0] base;
    } hdr_vec_t;
    hdr_vec_t vecs[6];

    logic [31:0] exp_rows[2][NR];
    logic        err_exp = 1'b0;
    int          run = 0;
    logic [NF-1:0] cap = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic clear_models();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < NR; r++)
                exp_rows[d][r] = 32'd0;
        err_exp = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_pct);
        int guard;
        int idle;
        idle = 0;
        while (gap_pct > 0 && idle < 8 && $urandom_range(99) < gap_pct) begin
            cfg_valid = 1'b0;
            @(posedge CLK); #1;
            idle++;
        end
        cfg_data  = w;
        cfg_valid = 1'b1;
        guard = 0;
        while (!obs_ready && guard < 50) begin
            @(posedge CLK); #1;
            guard++;
        end
        if (!obs_ready) begin
            check("ready_timeout", 64'(obs_ready), 64'd1);
            cfg_valid = 1'b0;
            return;
        end
        @(posedge CLK); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic send_rows(input logic [4:0] f, input logic [31:0] base, input int first,
                             input int nrows, input int gap, input bit expect_strobe);
        for (int r = first; r < first + nrows; r++) begin
            if (r == NR - 1 && expect_strobe)
                sb_q.push_back('{strobe: NF'(1) << f, width: (sel ? 3 : 1)});
            send_word(base + 32'(r), gap);
            exp_rows[sel][r] = base + 32'(r);
        end
    endtask

    task automatic send_frame(input logic [4:0] f, input logic [31:0] base, input int nrows,
                              input int gap, input bit expect_strobe);
        $display("frame: dut=%0d f=%0d base=%h rows=%0d gap=%0d%%", sel, f, base, nrows, gap);
        send_word({12'hFAB, 15'd0, f}, gap);
        send_rows(f, base, 0, nrows, gap, expect_strobe);
    endtask

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        while (obs_busy && g < 40) begin
            @(posedge CLK); #1;
            g++;
        end
        check(name, 64'(obs_busy), 64'd0);
    endtask

    task automatic check_rows(input string name);
        for (int r = 0; r < NR; r++)
            check($sformatf("%s[%0d]", name, r), 64'(obs_data[r*32 +: 32]), 64'(exp_rows[sel][r]));
    endtask

    task automatic do_reset(input string name);
        resetn = 1'b0;
        #2;
        check({name, "_strobe"}, 64'(obs_strobe), 64'd0);
        check({name, "_data_zero"}, 64'(|obs_data), 64'd0);
        check({name, "_busy"}, 64'(obs_busy), 64'd0);
        check({name, "_ready"}, 64'(obs_ready), 64'd1);
        @(posedge CLK); #1;
        resetn = 1'b1;
        clear_models();
        $display("reset: %s", name);
    endtask

    // Per-cycle invariants on both instances plus the strobe scoreboard on the observed one.
    always @(negedge CLK) begin
        check("onehot_a", 64'($onehot0(strobe_a)), 64'd1);
        check("onehot_b", 64'($onehot0(strobe_b)), 64'd1);
        check("strobe_busy_a", 64'((strobe_a != 0) && !busy_a), 64'd0);
        check("strobe_busy_b", 64'((strobe_b != 0) && !busy_b), 64'd0);
        check("xfer_in_strobe_a", 64'((strobe_a != 0) && bus_a.cfg_valid && bus_a.cfg_ready), 64'd0);
        check("xfer_in_strobe_b", 64'((strobe_b != 0) && bus_b.cfg_valid && bus_b.cfg_ready), 64'd0);
        if (!resetn) begin
            run = 0;
        end else if (obs_strobe != 0) begin
            if (run == 0) cap = obs_strobe;
            else check("strobe_stable", 64'(obs_strobe), 64'(cap));
            run++;
        end else if (run > 0) begin
            check("done_after_strobe", 64'(obs_done), 64'd1);
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", 64'(cap), 64'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check("strobe_value", 64'(cap), 64'(sb_e.strobe));
                check("strobe_width", 64'(run), 64'(sb_e.width));
            end
            run = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{word: 32'hFAB0_0014, accept: 1'b0, base: 32'h0};
        vecs[1] = '{word: 32'h1230_0001, accept: 1'b0, base: 32'h0};
        vecs[2] = '{word: 32'hFAB0_001F, accept: 1'b0, base: 32'h0};
        vecs[3] = '{word: 32'hFABF_FFE0, accept: 1'b1, base: 32'h3000_0000};
        vecs[4] = '{word: 32'hFAA0_0002, accept: 1'b0, base: 32'h0};
        vecs[5] = '{word: 32'hFAB0_0013, accept: 1'b1, base: 32'h4000_0000};
        clear_models();

        // Reset state
        #3;
        check("rst_strobe", 64'(obs_strobe), 64'd0);
        check("rst_data", 64'(|obs_data), 64'd0);
        check("rst_done", 64'(obs_done), 64'd0);
        check("rst_err", 64'(obs_err), 64'd0);
        check("rst_busy", 64'(obs_busy), 64'd0);
        @(posedge CLK); #1;
        resetn = 1'b1;
        check("rst_ready", 64'(obs_ready), 64'd1);

        // Back-to-back frame, strobe the cycle after row 15
        send_frame(5'd3, 32'h1000_0000, NR, 0, 1'b1);
        check("s1_strobe_first", 64'(obs_strobe), 64'h8);
        check("s1_done_early", 64'(obs_done), 64'd0);
        check("s1_ready_strobe", 64'(obs_ready), 64'd0);
        @(posedge CLK); #1;
        check("s1_strobe_off", 64'(obs_strobe), 64'd0);
        check("s1_done", 64'(obs_done), 64'd1);
        check("s1_busy_gap", 64'(obs_busy), 64'd1);
        @(posedge CLK); #1;
        check("s1_done_pulse", 64'(obs_done), 64'd0);
        check("s1_idle", 64'(obs_busy), 64'd0);
        check("s1_ready_idle", 64'(obs_ready), 64'd1);
        check_rows("s1_row");

        // Header table
        foreach (vecs[i]) begin
            if (!vecs[i].accept) err_exp = 1'b1;
            $display("header: %h", vecs[i].word);
            send_word(vecs[i].word, 0);
            check($sformatf("s2_busy_%0d", i), 64'(obs_busy), 64'(vecs[i].accept));
            check($sformatf("s2_err_%0d", i), 64'(obs_err), 64'(err_exp));
            check($sformatf("s2_strobe_%0d", i), 64'(obs_strobe), 64'd0);
            if (vecs[i].accept) begin
                send_rows(vecs[i].word[4:0], vecs[i].base, 0, NR, 0, 1'b1);
                wait_idle($sformatf("s2_idle_%0d", i));
                check_rows($sformatf("s2_row_%0d", i));
            end
        end
        err_clr = 1'b1;
        @(posedge CLK); #1;
        err_clr = 1'b0;
        err_exp = 1'b0;
        check("s2_err_clr", 64'(obs_err), 64'(err_exp));
        err_clr = 1'b1;
        send_word(32'h1230_0001, 0);
        err_clr = 1'b0;
        err_exp = 1'b1;
        check("s2_set_wins", 64'(obs_err), 64'(err_exp));
        err_clr = 1'b1;
        @(posedge CLK); #1;
        err_clr = 1'b0;
        err_exp = 1'b0;
        check("s2_err_clr2", 64'(obs_err), 64'(err_exp));

        // Three-cycle strobe instance with random valid gaps
        sel = 1'b1;
        send_frame(5'd3, 32'h1000_0000, NR, 50, 1'b1);
        cfg_data  = 32'hFAB0_0005;
        cfg_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("s3_ready_low_%0d", k), 64'(obs_ready), 64'd0);
            check($sformatf("s3_strobe_%0d", k), 64'(obs_strobe), (k < 3) ? 64'h8 : 64'd0);
            check($sformatf("s3_done_%0d", k), 64'(obs_done), (k == 3) ? 64'd1 : 64'd0);
            if (k == 3) cfg_valid = 1'b0;
            @(posedge CLK); #1;
        end
        check("s3_idle", 64'(obs_busy), 64'd0);
        check("s3_ready_idle", 64'(obs_ready), 64'd1);
        check_rows("s3_row");

        // Partial frame then stall; row 4 carries a header-looking data word
        sel = 1'b0;
        send_frame(5'd19, 32'hFAB0_0010, 8, 0, 1'b0);
        repeat (5) begin
            @(posedge CLK); #1;
        end
        check("s4_busy", 64'(obs_busy), 64'd1);
        check("s4_no_strobe", 64'(obs_strobe), 64'd0);
        check("s4_ready", 64'(obs_ready), 64'd1);
        check("s4_err", 64'(obs_err), 64'(err_exp));
        check_rows("s4_row");

        // Reset after row 9, then reset during the strobe
        send_rows(5'd19, 32'hFAB0_0010, 8, 2, 0, 1'b0);
        do_reset("s5_load");
        check_rows("s5_row_cleared");
        send_frame(5'd5, 32'h7000_0000, NR, 0, 1'b0);
        check("s5_strobe_up", 64'(obs_strobe), 64'h20);
        do_reset("s5_strobe");
        check("s5_err", 64'(obs_err), 64'd0);
        send_frame(5'd7, 32'h5000_0000, NR, 0, 1'b1);
        wait_idle("s5_idle");
        check_rows("s5_row");

        repeat (3) begin
            @(posedge CLK); #1;
        end
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
